// File: rtl/ccip_avmm_mmio_rsp_guard.sv
// -----------------------------------------------------------------------------
// ccip_avmm_mmio_rsp_guard
//
// Sits between the CCI-P MMIO-to-Avalon bridge (s_*) and the AFU's Avalon-MM
// MMIO fabric (m_*). Commands pass through combinationally. Every accepted
// read is tracked so that the number of reads in flight stays bounded. A read
// is answered upstream exactly once, because CCI-P requires every MMIO read to
// be answered.
//
// Optional feature, enabled by defining CCIP_AVMM_MMIO_RSP_TIMEOUT_EN:
//   If the oldest read is not answered within TIMEOUT_CYCLES, a substitute
//   response carrying TIMEOUT_DATA is returned. The late real response is
//   dropped later, which keeps the upstream responses in order.
//   Without the macro, reads wait indefinitely and timeout_count reads 0.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   s_address/s_read/s_write/s_writedata/s_byteenable
//                         upstream command
//   s_waitrequest         stall to upstream (also asserted when too many
//                         reads are outstanding)
//   s_readdata/s_readdatavalid
//                         registered response to upstream
//   m_address/m_read/m_write/m_writedata/m_byteenable
//                         command to fabric
//   m_waitrequest         fabric stall
//   m_readdata/m_readdatavalid
//                         fabric response (in order)
//   timeout_count         saturating count of substitute responses
//   rsp_error             sticky: response seen while nothing was outstanding
// -----------------------------------------------------------------------------
module ccip_avmm_mmio_rsp_guard #(
    parameter int                    DATA_WIDTH     = 64,
    parameter int                    ADDR_WIDTH     = 18,
    parameter int                    MAX_PENDING    = 64,
    parameter int                    TIMEOUT_CYCLES = 4096,
    parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA   = '1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [ADDR_WIDTH-1:0]   s_address,
    input  logic                    s_read,
    input  logic                    s_write,
    input  logic [DATA_WIDTH-1:0]   s_writedata,
    input  logic [DATA_WIDTH/8-1:0] s_byteenable,
    output logic                    s_waitrequest,
    output logic [DATA_WIDTH-1:0]   s_readdata,
    output logic                    s_readdatavalid,
    output logic [ADDR_WIDTH-1:0]   m_address,
    output logic                    m_read,
    output logic                    m_write,
    output logic [DATA_WIDTH-1:0]   m_writedata,
    output logic [DATA_WIDTH/8-1:0] m_byteenable,
    input  logic                    m_waitrequest,
    input  logic [DATA_WIDTH-1:0]   m_readdata,
    input  logic                    m_readdatavalid,
    output logic [15:0]             timeout_count,
    output logic                    rsp_error
);

    localparam int CNT_W = $clog2(MAX_PENDING) + 1;

    logic [CNT_W-1:0]      pend_q, pend_d;
    logic [CNT_W-1:0]      drop;        // reads already answered by a substitute
    logic [CNT_W:0]        inflight;
    logic                  full;
    logic                  accept;
    logic                  rsp_drop, rsp_fwd, rsp_spur;
    logic                  tmo_evt;
    logic                  rdv_q, rdv_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;

    // Command path: zero latency; only reads are gated when the budget is used.
    assign inflight      = {1'b0, pend_q} + {1'b0, drop};
    assign full          = (inflight == (CNT_W+1)'(MAX_PENDING));
    assign m_address     = s_address;
    assign m_writedata   = s_writedata;
    assign m_byteenable  = s_byteenable;
    assign m_read        = s_read & ~full;
    assign m_write       = s_write;
    assign s_waitrequest = m_waitrequest | (s_read & full);
    assign accept        = m_read & ~m_waitrequest;

    // Responses are in order: the oldest ones belong to reads that timed out.
    assign rsp_drop = m_readdatavalid & (drop != '0);
    assign rsp_fwd  = m_readdatavalid & (drop == '0) & (pend_q != '0);
    assign rsp_spur = m_readdatavalid & (drop == '0) & (pend_q == '0);

`ifdef CCIP_AVMM_MMIO_RSP_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);

    logic [TMR_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [15:0]      tcnt_q, tcnt_d;

    // A real response in the expiry cycle wins over the substitute.
    assign tmo_evt = ~m_readdatavalid & (pend_q != '0) &
                     (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));
    assign drop          = drop_q;
    assign timeout_count = tcnt_q;

    always_comb begin
        drop_d  = drop_q + CNT_W'(tmo_evt) - CNT_W'(rsp_drop);
        tcnt_d  = (tmo_evt && tcnt_q != 16'hFFFF) ? tcnt_q + 16'd1 : tcnt_q;
        timer_d = timer_q;
        if (pend_q == '0 || rsp_fwd || tmo_evt) begin
            timer_d = '0;
        end else if (timer_q != TMR_W'(TIMEOUT_CYCLES - 1)) begin
            timer_d = timer_q + TMR_W'(1);
        end
        // Otherwise hold at expiry: a dropped late response landed exactly
        // in the expiry cycle, so the substitute goes out on the next one.
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer_q <= '0;
            drop_q  <= '0;
            tcnt_q  <= '0;
        end else begin
            timer_q <= timer_d;
            drop_q  <= drop_d;
            tcnt_q  <= tcnt_d;
        end
    end
`else
    logic unused_tmo_cfg;

    assign tmo_evt        = 1'b0;
    assign drop           = '0;
    assign timeout_count  = '0;
    // Timeout length is irrelevant when reads wait indefinitely.
    assign unused_tmo_cfg = (TIMEOUT_CYCLES < 4);
`endif

    always_comb begin
        pend_d  = pend_q + CNT_W'(accept) - CNT_W'(rsp_fwd | tmo_evt);
        err_d   = err_q | rsp_spur;
        rdv_d   = rsp_fwd | tmo_evt;
        rdata_d = rdata_q;
        if (rsp_fwd) begin
            rdata_d = m_readdata;
        end else if (tmo_evt) begin
            rdata_d = TIMEOUT_DATA;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q  <= '0;
            err_q   <= 1'b0;
            rdv_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            pend_q  <= pend_d;
            err_q   <= err_d;
            rdv_q   <= rdv_d;
            rdata_q <= rdata_d;
        end
    end

    assign s_readdatavalid = rdv_q;
    assign s_readdata      = rdata_q;
    assign rsp_error       = err_q;

endmodule
